sdram_arbiter: RTL and testbench

Two-port arbiter that shares the single SDRAM controller memory interface between two independent requesters, e.g. port 0 = CPU data path, port 1 = DMA / instruction fetch. Each port issues one-cycle chip-select pulses with a full 32-bit access. The arbiter latches the request, serialises the pending requests onto the controller one at a time and routes the controller acknowledge back to the owning port. It sits between the bus fabric and the SDRAM controller.

---
 rtl/sdram_arbiter_if.sv | 24 ++
 rtl/sdram_arbiter.sv | 149 ++++++++++++++
 tb/tb_sdram_arbiter.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_arbiter_if.sv
// One request/acknowledge channel into or out of the SDRAM arbiter; the requester uses master, the servicing side uses slave.
// Purely combinational wiring: no latency and no backpressure of its own beyond the cs/ack pulse protocol.
interface sdram_arbiter_if #(
   parameter int DATA_BITS = 32,
   parameter int ADDR_BITS = 24
);
   logic                   cs;
   logic                   read0_write1;
   logic [DATA_BITS/8-1:0] byteenable;
   logic [ADDR_BITS-1:0]   addr;
   logic [DATA_BITS-1:0]   write_data;
   logic                   ack;
   logic [DATA_BITS-1:0]   read_data;

   modport master (
      output cs, read0_write1, byteenable, addr, write_data,
      input  ack, read_data
   );

   modport slave (
      input  cs, read0_write1, byteenable, addr, write_data,
      output ack, read_data
   );
endinterface

// File: rtl/sdram_arbiter.sv
// Two-port arbiter serialising latched requests onto one SDRAM controller; SDRAM_ARB_FIXED_PRIORITY_EN selects fixed priority (port 0 wins ties).
// Issue latency 2 cycles from pN_cs, pN_ack in the same cycle as mem_ack; one outstanding transaction, a pN_cs while that port is pending is dropped.
module sdram_arbiter #(
   parameter int DATA_BITS = 32,
   parameter int ADDR_BITS = 24
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            sync_reset,
   sdram_arbiter_if.slave  p0,
   sdram_arbiter_if.slave  p1,
   sdram_arbiter_if.master mem,
   output logic            busy,
   output logic            grant
);
   localparam int BE_BITS = DATA_BITS / 8;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK} state_t;

   state_t               r_state;
   logic                 r_grant;
   logic [1:0]           r_pend;
   logic                 r_rw   [2];
   logic [BE_BITS-1:0]   r_be   [2];
   logic [ADDR_BITS-1:0] r_addr [2];
   logic [DATA_BITS-1:0] r_wd   [2];

   logic                 r_mem_cs;
   logic                 r_mem_rw;
   logic [BE_BITS-1:0]   r_mem_be;
   logic [ADDR_BITS-1:0] r_mem_addr;
   logic [DATA_BITS-1:0] r_mem_wd;

   logic [1:0]           w_cs;
   logic [1:0]           w_ack;
   logic                 w_rw   [2];
   logic [BE_BITS-1:0]   w_be   [2];
   logic [ADDR_BITS-1:0] w_addr [2];
   logic [DATA_BITS-1:0] w_wd   [2];
   logic                 w_win;

   assign w_cs      = {p1.cs, p0.cs};
   assign w_rw[0]   = p0.read0_write1;
   assign w_rw[1]   = p1.read0_write1;
   assign w_be[0]   = p0.byteenable;
   assign w_be[1]   = p1.byteenable;
   assign w_addr[0] = p0.addr;
   assign w_addr[1] = p1.addr;
   assign w_wd[0]   = p0.write_data;
   assign w_wd[1]   = p1.write_data;

   // Acks outside WAIT_ACK belong to no transaction of ours and are dropped.
   assign w_ack[0] = (r_state == WAIT_ACK) && mem.ack && !r_grant;
   assign w_ack[1] = (r_state == WAIT_ACK) && mem.ack &&  r_grant;

`ifdef SDRAM_ARB_FIXED_PRIORITY_EN
   assign w_win = (r_pend == 2'b11) ? 1'b0 : r_pend[1];
`else
   assign w_win = (r_pend == 2'b11) ? ~r_grant : r_pend[1];
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pend <= '0;
         for (int i = 0; i < 2; i++) begin
            r_rw[i]   <= 1'b0;
            r_be[i]   <= '0;
            r_addr[i] <= '0;
            r_wd[i]   <= '0;
         end
      end else if (sync_reset) begin
         r_pend <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            // A new request in the ack cycle re-arms the slot; otherwise a pending slot is never overwritten.
            if (w_cs[i] && (!r_pend[i] || w_ack[i])) begin
               r_pend[i] <= 1'b1;
               r_rw[i]   <= w_rw[i];
               r_be[i]   <= w_be[i];
               r_addr[i] <= w_addr[i];
               r_wd[i]   <= w_wd[i];
            end else if (w_ack[i]) begin
               r_pend[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= IDLE;
         r_grant    <= 1'b1;
         r_mem_cs   <= 1'b0;
         r_mem_rw   <= 1'b0;
         r_mem_be   <= '0;
         r_mem_addr <= '0;
         r_mem_wd   <= '0;
      end else if (sync_reset) begin
         r_state    <= IDLE;
         r_grant    <= 1'b1;
         r_mem_cs   <= 1'b0;
         r_mem_rw   <= 1'b0;
         r_mem_be   <= '0;
         r_mem_addr <= '0;
         r_mem_wd   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (|r_pend) begin
                  r_grant    <= w_win;
                  r_mem_cs   <= 1'b1;
                  r_mem_rw   <= r_rw[w_win];
                  r_mem_be   <= r_be[w_win];
                  r_mem_addr <= r_addr[w_win];
                  r_mem_wd   <= r_wd[w_win];
                  r_state    <= ISSUE;
               end
            end
            ISSUE: begin
               r_mem_cs <= 1'b0;
               r_state  <= WAIT_ACK;
            end
            WAIT_ACK: begin
               if (mem.ack) begin
                  r_state <= IDLE;
               end
            end
            default: begin
               r_mem_cs <= 1'b0;
               r_state  <= IDLE;
            end
         endcase
      end
   end

   assign mem.cs           = r_mem_cs;
   assign mem.read0_write1 = r_mem_rw;
   assign mem.byteenable   = r_mem_be;
   assign mem.addr         = r_mem_addr;
   assign mem.write_data   = r_mem_wd;

   assign p0.ack       = w_ack[0];
   assign p1.ack       = w_ack[1];
   assign p0.read_data = mem.read_data;
   assign p1.read_data = mem.read_data;

   assign busy  = (r_state != IDLE);
   assign grant = r_grant;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: requests are queued as expected controller transactions and checked when mem_cs appears.
// Inputs change and outputs are sampled 1 time unit after the rising clock edge.
module tb_sdram_arbiter;
   logic clk = 1'b0;
   logic reset_n;
   logic sync_reset;
   logic busy;
   logic grant;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      bit          port;
      bit          rw;
      logic [3:0]  be;
      logic [23:0] addr;
      logic [31:0] wd;
   } req_t;

   req_t sb[$];

   sdram_arbiter_if #(.DATA_BITS(32), .ADDR_BITS(24)) p0_if();
   sdram_arbiter_if #(.DATA_BITS(32), .ADDR_BITS(24)) p1_if();
   sdram_arbiter_if #(.DATA_BITS(32), .ADDR_BITS(24)) mem_if();

   sdram_arbiter #(.DATA_BITS(32), .ADDR_BITS(24)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .sync_reset (sync_reset),
      .p0         (p0_if),
      .p1         (p1_if),
      .mem        (mem_if),
      .busy       (busy),
      .grant      (grant)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input bit port, input bit rw, input logic [3:0] be,
                      input logic [23:0] addr, input logic [31:0] wd, input bit push);
      req_t e;
      if (port) begin
         p1_if.cs = 1'b1; p1_if.read0_write1 = rw; p1_if.byteenable = be;
         p1_if.addr = addr; p1_if.write_data = wd;
      end else begin
         p0_if.cs = 1'b1; p0_if.read0_write1 = rw; p0_if.byteenable = be;
         p0_if.addr = addr; p0_if.write_data = wd;
      end
      if (push) begin
         e.port = port; e.rw = rw; e.be = be; e.addr = addr; e.wd = wd;
         sb.push_back(e);
      end
   endtask

   task automatic clr_cs();
      p0_if.cs = 1'b0;
      p1_if.cs = 1'b0;
   endtask

   // Waits for mem_cs, then checks the issued fields against the oldest queued request.
   task automatic expect_issue(input string tag, input int exp_wait);
      int   n = 0;
      req_t e;
      while (mem_if.cs !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      chk({tag, "_issue_seen"}, mem_if.cs, 1);
      chk({tag, "_issue_wait"}, n, exp_wait);
      chk({tag, "_sb_nonempty"}, sb.size() != 0, 1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk({tag, "_grant"}, grant, e.port);
         chk({tag, "_rw"},    mem_if.read0_write1, e.rw);
         chk({tag, "_be"},    mem_if.byteenable, e.be);
         chk({tag, "_addr"},  mem_if.addr, e.addr);
         chk({tag, "_wdata"}, mem_if.write_data, e.wd);
      end
   endtask

   task automatic do_ack(input string tag, input bit port, input logic [31:0] rd);
      mem_if.ack = 1'b1;
      mem_if.read_data = rd;
      #1;
      chk({tag, "_p0_ack"}, p0_if.ack, port == 1'b0);
      chk({tag, "_p1_ack"}, p1_if.ack, port == 1'b1);
      chk({tag, "_p0_rdata"}, p0_if.read_data, rd);
      chk({tag, "_p1_rdata"}, p1_if.read_data, rd);
      step();
      mem_if.ack = 1'b0;
      mem_if.read_data = '0;
   endtask

   task automatic quiet(input string tag, input int cycles);
      int cs_n = 0;
      int ack_n = 0;
      for (int i = 0; i < cycles; i++) begin
         if (mem_if.cs === 1'b1) cs_n++;
         if (p0_if.ack === 1'b1 || p1_if.ack === 1'b1) ack_n++;
         step();
      end
      chk({tag, "_no_issue"}, cs_n, 0);
      chk({tag, "_no_ack"}, ack_n, 0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_mem_cs"},   mem_if.cs, 0);
      chk({tag, "_mem_rw"},   mem_if.read0_write1, 0);
      chk({tag, "_mem_be"},   mem_if.byteenable, 0);
      chk({tag, "_mem_addr"}, mem_if.addr, 0);
      chk({tag, "_mem_wd"},   mem_if.write_data, 0);
      chk({tag, "_busy"},     busy, 0);
      chk({tag, "_grant"},    grant, 1);
      chk({tag, "_p0_ack"},   p0_if.ack, 0);
      chk({tag, "_p1_ack"},   p1_if.ack, 0);
   endtask

   initial begin
      reset_n = 1'b0;
      sync_reset = 1'b0;
      p0_if.cs = 1'b0; p0_if.read0_write1 = 1'b0; p0_if.byteenable = '0; p0_if.addr = '0; p0_if.write_data = '0;
      p1_if.cs = 1'b0; p1_if.read0_write1 = 1'b0; p1_if.byteenable = '0; p1_if.addr = '0; p1_if.write_data = '0;
      mem_if.ack = 1'b0; mem_if.read_data = '0;

      // Reset state
      step(); step();
      chk_reset_vals("rst");
      reset_n = 1'b1;
      step();

      // Single read on port 0, with an ack during ISSUE that must be ignored
      req(1'b0, 1'b0, 4'hF, 24'h000100, 32'h0, 1'b1);
      step();
      clr_cs();
      chk("rd_busy_t1", busy, 0);
      expect_issue("rd", 1);
      chk("rd_busy_issue", busy, 1);
      mem_if.ack = 1'b1;
      #1;
      chk("rd_issue_ack_p0", p0_if.ack, 0);
      chk("rd_issue_ack_p1", p1_if.ack, 0);
      step();
      mem_if.ack = 1'b0;
      chk("rd_mem_cs_one_cycle", mem_if.cs, 0);
      do_ack("rd", 1'b0, 32'hDEADBEEF);
      chk("rd_idle_after_ack", busy, 0);

      // reset_n asserted while the request is in ISSUE
      req(1'b0, 1'b1, 4'h3, 24'h000040, 32'hCAFEF00D, 1'b1);
      step();
      clr_cs();
      expect_issue("arst", 1);
      reset_n = 1'b0;
      #1;
      chk_reset_vals("arst");
      step();
      reset_n = 1'b1;
      quiet("arst", 4);

      // Tie from reset: port 0 first, then port 1 after the ack
      req(1'b0, 1'b1, 4'hF, 24'h000010, 32'h11111111, 1'b1);
      req(1'b1, 1'b1, 4'hC, 24'h000020, 32'h22222222, 1'b1);
      step();
      clr_cs();
      expect_issue("tieA0", 1);
      step();
      do_ack("tieA0", 1'b0, 32'h0);
      expect_issue("tieA1", 1);
      step();
      do_ack("tieA1", 1'b1, 32'h0);

      // Port 0 alone makes it the last grant before the second tie
      req(1'b0, 1'b0, 4'hF, 24'h000030, 32'h0, 1'b1);
      step();
      clr_cs();
      expect_issue("solo", 1);
      step();
      do_ack("solo", 1'b0, 32'h12345678);

      // Second tie: round-robin favours port 1, fixed priority keeps port 0
      req(1'b0, 1'b1, 4'h1, 24'h000050, 32'h55555555, 1'b0);
      req(1'b1, 1'b1, 4'h8, 24'h000060, 32'h66666666, 1'b0);
`ifdef SDRAM_ARB_FIXED_PRIORITY_EN
      sb.push_back('{port: 1'b0, rw: 1'b1, be: 4'h1, addr: 24'h000050, wd: 32'h55555555});
      sb.push_back('{port: 1'b1, rw: 1'b1, be: 4'h8, addr: 24'h000060, wd: 32'h66666666});
`else
      sb.push_back('{port: 1'b1, rw: 1'b1, be: 4'h8, addr: 24'h000060, wd: 32'h66666666});
      sb.push_back('{port: 1'b0, rw: 1'b1, be: 4'h1, addr: 24'h000050, wd: 32'h55555555});
`endif
      step();
      clr_cs();
      expect_issue("tieB0", 1);
      step();
`ifdef SDRAM_ARB_FIXED_PRIORITY_EN
      do_ack("tieB0", 1'b0, 32'h0);
`else
      do_ack("tieB0", 1'b1, 32'h0);
`endif
      expect_issue("tieB1", 1);
      step();
`ifdef SDRAM_ARB_FIXED_PRIORITY_EN
      do_ack("tieB1", 1'b1, 32'h0);
`else
      do_ack("tieB1", 1'b0, 32'h0);
`endif

      // Back-to-back on port 1: new pulse in the same cycle as its ack
      req(1'b1, 1'b0, 4'hF, 24'h000070, 32'h0, 1'b1);
      step();
      clr_cs();
      expect_issue("b2b0", 1);
      step();
      req(1'b1, 1'b1, 4'h6, 24'h000071, 32'hA5A5A5A5, 1'b1);
      do_ack("b2b0", 1'b1, 32'h0BADF00D);
      clr_cs();
      expect_issue("b2b1", 1);
      step();
      do_ack("b2b1", 1'b1, 32'h0);

      // Re-request on port 0 while pending is dropped
      req(1'b0, 1'b0, 4'hF, 24'h000001, 32'h0, 1'b1);
      step();
      req(1'b0, 1'b1, 4'h0, 24'h000002, 32'hFFFFFFFF, 1'b0);
      step();
      clr_cs();
      expect_issue("dup", 0);
      step();
      do_ack("dup", 1'b0, 32'h00000001);
      quiet("dup", 6);

      // sync_reset in WAIT_ACK abandons the transaction; a stray ack afterwards is ignored
      req(1'b1, 1'b0, 4'hF, 24'h000080, 32'h0, 1'b1);
      step();
      clr_cs();
      expect_issue("srst", 1);
      step();
      chk("srst_busy_wait", busy, 1);
      sync_reset = 1'b1;
      step();
      sync_reset = 1'b0;
      chk("srst_busy_idle", busy, 0);
      chk("srst_mem_cs", mem_if.cs, 0);
      mem_if.ack = 1'b1;
      mem_if.read_data = 32'h77777777;
      #1;
      chk("srst_stray_p0_ack", p0_if.ack, 0);
      chk("srst_stray_p1_ack", p1_if.ack, 0);
      step();
      mem_if.ack = 1'b0;
      quiet("srst", 6);
      chk("sb_drained", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
